md_issue_queue: RTL and testbench
=================================

Name: md_issue_queue

Overview:
- Sits between the D/E pipeline boundary and the multiply/divide unit.
- Buffers mult/multu/div/divu/mtlo/mthi/mfhi/mflo requests in a small FIFO and issues them to the unit only when it is idle.
- Captures mfhi/mflo read data into a result register with a valid/ready handshake toward the E/M stage.
- Lets D keep issuing MD instructions while a long divide is in flight; the hazard unit stalls only when the queue is full or a result is pending.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous active-high; discards all queued, unissued entries.
- in_valid  in  1  request present from D/E.
- in_ready  out  1  queue can accept; equals !full.
- in_op  in  4  MD op code (`MD_* from Defines.v; 4'd0 = no operation).
- in_rs  in  32  RS operand.
- in_rt  in  32  RT operand.
- in_dst  in  5  destination GPR, meaningful for mfhi/mflo only.
- md_op  out  4  op driven to the multiply/divide unit.
- md_rs  out  32  RS to the unit.
- md_rt  out  32  RT to the unit.
- md_busy  in  1  busy from the unit; combinational, includes its own start term.
- md_out  in  32  read data from the unit; combinational on md_op.
- res_valid  out  1  captured mfhi/mflo result available.
- res_ready  in  1  consumer accepts the result.
- res_dst  out  5  destination of the captured result.
- res_data  out  32  captured HI or LO value.
- pending  out  1  queue non-empty, or state ISSUE, or md_busy; consumed by the hazard unit.

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty, pointers 0, state IDLE.
  - md_op = 0, md_rs = md_rt = 0.
  - res_valid = 0, res_dst = 0, res_data = 0.
  - Reset mid-divide drops everything; the unit's own reset handles the unit.
- Enqueue:
  - Push {op, rs, rt, dst} when in_valid && in_ready && in_op != 0.
  - in_op == 0 with in_valid high is accepted and discarded.
  - No push-while-full bypass; in_ready depends only on occupancy.
- FSM, two states:
  - IDLE: md_op = 0, md_rs = md_rt = 0. Go to ISSUE when the FIFO is non-empty, md_busy == 0, and the head is not mfhi/mflo while res_valid && !res_ready. Otherwise stay.
  - ISSUE: drive the head op/rs/rt on md_* for exactly one cycle, pop at the closing edge, return to IDLE.
  - md_busy is sampled only in IDLE, where md_op = 0, so it reflects only the unit's counter. This removes the start-term loop.
- Throughput and latency:
  - At most one issue per two cycles.
  - Entry pushed at edge E0 with queue empty and unit idle: IDLE decides in cycle E0..E1, ISSUE runs in cycle E1..E2.
  - After a mult issue, IDLE sees md_busy for 5 cycles; after a div issue, for 10 cycles.
- Result capture:
  - In ISSUE with head mfhi/mflo, at the closing edge: res_data <= md_out, res_dst <= head dst, res_valid <= 1.
  - res_valid clears on res_valid && res_ready when no new capture happens in the same edge.
  - A capture and a consume in the same edge are legal; the new result is loaded and res_valid stays 1.
  - Held stable while res_valid && !res_ready.
- flush:
  - Empties the FIFO at the edge.
  - An ISSUE already in progress completes, including its pop and any capture.
  - A push in the same cycle as flush is dropped.
  - The result register is unaffected.
- Pointers are log2(DEPTH) bits plus a wrap bit; full when indices are equal and wrap bits differ.
- Simultaneous push and pop when not full: occupancy is unchanged.

Test Plan:
- Reset, push mult rs=7 rt=-3, then mflo dst=8 → mult issued once; mflo issued only after md_busy clears (5 cycles). res_data = 0xFFFFFFEB, res_dst = 8, res_valid = 1.
- Push div 100/7 then mfhi with res_ready = 1 → div issued, 10 busy cycles, then mfhi. res_data = 2, single-cycle res_valid.
- DEPTH = 2: push three ops back-to-back while the unit is busy → in_ready drops after 2. The third is accepted after the first issue; order is preserved.
- res_ready = 0 with two mflo queued → first captured and held; second not issued until res_ready = 1. Both delivered in order.
- flush asserted while two entries are queued and ISSUE is active → the issued op completes, the remaining entry is discarded, pending falls once md_busy clears.
- Assert rst_n low mid-divide with res_valid = 1 → all outputs at reset values immediately, FIFO empty.

Source files
------------

// File: rtl/md_issue_queue.sv
// md_issue_queue
// Buffers multiply/divide requests from the D/E boundary and hands them to the
// MD unit one at a time, only while the unit is idle. mfhi/mflo read data is
// captured into a result register offered to E/M with a valid/ready handshake,
// so D can keep queuing MD work while a long divide runs.
module md_issue_queue #(
  parameter int unsigned DEPTH   = 2,
  parameter logic [3:0]  MD_MFHI = 4'd7,
  parameter logic [3:0]  MD_MFLO = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_dst,
  output logic [3:0]  md_op,
  output logic [31:0] md_rs,
  output logic [31:0] md_rt,
  input  logic        md_busy,
  input  logic [31:0] md_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_dst,
  output logic [31:0] res_data,
  output logic        pending
);

  // state    | meaning
  // ST_IDLE  | md_* held at zero; waiting for a head entry the unit can take
  // ST_ISSUE | head presented on md_* for one cycle, popped at the closing edge

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e       state_q;

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx, rd_idx;

  logic [3:0]    fifo_op_q  [DEPTH];
  logic [31:0]   fifo_rs_q  [DEPTH];
  logic [31:0]   fifo_rt_q  [DEPTH];
  logic [4:0]    fifo_dst_q [DEPTH];

  logic [3:0]    head_op;
  logic [31:0]   head_rs, head_rt;
  logic [4:0]    head_dst;

  logic          empty, full;
  logic          push, pop;
  logic          head_is_mf, issue_is_mf;
  logic          res_blocked, can_issue, capture;

  logic [3:0]    md_op_q;
  logic [31:0]   md_rs_q, md_rt_q;
  logic [4:0]    md_dst_q;

  logic          res_valid_q;
  logic [4:0]    res_dst_q;
  logic [31:0]   res_data_q;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign head_op  = fifo_op_q[rd_idx];
  assign head_rs  = fifo_rs_q[rd_idx];
  assign head_rt  = fifo_rt_q[rd_idx];
  assign head_dst = fifo_dst_q[rd_idx];

  assign head_is_mf  = (head_op == MD_MFHI) || (head_op == MD_MFLO);
  assign issue_is_mf = (md_op_q == MD_MFHI) || (md_op_q == MD_MFLO);

  // An unconsumed result must not be overwritten, so mfhi/mflo wait for it to drain.
  assign res_blocked = res_valid_q && !res_ready;

  // md_busy is only looked at in IDLE where md_op is zero, so it carries only
  // the unit's own counter and not its start term. A flush cancels the decision
  // because the head is being discarded at the same edge.
  assign can_issue = !empty && !md_busy && !flush && !(head_is_mf && res_blocked);

  assign capture = (state_q == ST_ISSUE) && issue_is_mf;

  // Pointer next-state: a flush still honours the pop of an ISSUE in flight.
  always_comb begin
    push     = in_valid && !full && (in_op != 4'd0) && !flush;
    pop      = (state_q == ST_ISSUE);
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (flush) begin
      wr_ptr_d = rd_ptr_d;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_idx]  <= in_op;
      fifo_rs_q[wr_idx]  <= in_rs;
      fifo_rt_q[wr_idx]  <= in_rt;
      fifo_dst_q[wr_idx] <= in_dst;
    end
  end

  // Issue FSM with registered md_* outputs; the head is latched on entry to ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      md_op_q  <= 4'd0;
      md_rs_q  <= 32'd0;
      md_rt_q  <= 32'd0;
      md_dst_q <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (can_issue) begin
            state_q  <= ST_ISSUE;
            md_op_q  <= head_op;
            md_rs_q  <= head_rs;
            md_rt_q  <= head_rt;
            md_dst_q <= head_dst;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_IDLE;
          md_op_q  <= 4'd0;
          md_rs_q  <= 32'd0;
          md_rt_q  <= 32'd0;
          md_dst_q <= 5'd0;
        end
        default: begin
          state_q  <= ST_IDLE;
          md_op_q  <= 4'd0;
          md_rs_q  <= 32'd0;
          md_rt_q  <= 32'd0;
          md_dst_q <= 5'd0;
        end
      endcase
    end
  end

  // Result register: a capture wins over a same-edge consume, so valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_dst_q   <= 5'd0;
      res_data_q  <= 32'd0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_dst_q   <= md_dst_q;
      res_data_q  <= md_out;
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign in_ready  = !full;
  assign md_op     = md_op_q;
  assign md_rs     = md_rs_q;
  assign md_rt     = md_rt_q;
  assign res_valid = res_valid_q;
  assign res_dst   = res_dst_q;
  assign res_data  = res_data_q;
  assign pending   = !empty || (state_q == ST_ISSUE) || md_busy;

endmodule

// File: tb/tb_md_issue_queue.sv
// tb_md_issue_queue
// Drives md_issue_queue against a small behavioural MD unit and checks the
// issue stream, handshakes and captured results against a queue-based model.
module tb_md_issue_queue;

  localparam int DEPTH = 2;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk, rst_n, flush, in_valid, res_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs, in_rt;
  logic [4:0]  in_dst;
  logic        in_ready, md_busy, res_valid, pending;
  logic [3:0]  md_op;
  logic [31:0] md_rs, md_rt, md_out, res_data;
  logic [4:0]  res_dst;

  md_issue_queue #(.DEPTH(DEPTH), .MD_MFHI(OP_MFHI), .MD_MFLO(OP_MFLO)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_dst(in_dst),
    .md_op(md_op), .md_rs(md_rs), .md_rt(md_rt),
    .md_busy(md_busy), .md_out(md_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dst(res_dst), .res_data(res_data), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiply/divide unit: 5-cycle multiply, 10-cycle divide.
  logic [3:0]  u_cnt;
  logic [31:0] u_hi, u_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt <= 4'd0;
      u_hi  <= 32'd0;
      u_lo  <= 32'd0;
    end else begin
      if (u_cnt != 4'd0) u_cnt <= u_cnt - 4'd1;
      case (md_op)
        OP_MULT:  begin {u_hi, u_lo} <= {{32{md_rs[31]}}, md_rs} * {{32{md_rt[31]}}, md_rt}; u_cnt <= 4'd5; end
        OP_MULTU: begin {u_hi, u_lo} <= {32'd0, md_rs} * {32'd0, md_rt}; u_cnt <= 4'd5; end
        OP_DIV:   begin u_lo <= $signed(md_rs) / $signed(md_rt); u_hi <= $signed(md_rs) % $signed(md_rt); u_cnt <= 4'd10; end
        OP_DIVU:  begin u_lo <= md_rs / md_rt; u_hi <= md_rs % md_rt; u_cnt <= 4'd10; end
        OP_MTHI:  u_hi <= md_rs;
        OP_MTLO:  u_lo <= md_rs;
        default:  ;
      endcase
    end
  end

  assign md_busy = (md_op == OP_MULT) || (md_op == OP_MULTU) || (md_op == OP_DIV) ||
                   (md_op == OP_DIVU) || (u_cnt != 4'd0);
  assign md_out  = (md_op == OP_MFHI) ? u_hi : (md_op == OP_MFLO) ? u_lo : 32'd0;

  // Reference model state.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dst;
  } ent_t;

  ent_t        mq[$];
  int          iss_cyc[$];
  logic [31:0] ref_hi, ref_lo, ref_data;
  logic [4:0]  ref_dst;
  logic        ref_valid, prev_blk, last_acc;
  int          cyc, last_iss;
  int          checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    ref_hi = 32'd0; ref_lo = 32'd0; ref_data = 32'd0; ref_dst = 5'd0;
    ref_valid = 1'b0; prev_blk = 1'b0; last_acc = 1'b0; last_iss = -10;
  endtask

  task automatic ref_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint p, q, r;
    logic [63:0] pu;
    case (op)
      OP_MULT:  begin p = longint'($signed(rs)) * longint'($signed(rt)); ref_hi = p[63:32]; ref_lo = p[31:0]; end
      OP_MULTU: begin pu = 64'(rs) * 64'(rt); ref_hi = pu[63:32]; ref_lo = pu[31:0]; end
      OP_DIV:   begin
        q = longint'($signed(rs)) / longint'($signed(rt));
        r = longint'($signed(rs)) % longint'($signed(rt));
        ref_lo = q[31:0]; ref_hi = r[31:0];
      end
      OP_DIVU:  begin ref_lo = rs / rt; ref_hi = rs % rt; end
      OP_MTHI:  ref_hi = rs;
      OP_MTLO:  ref_lo = rs;
      default:  ;
    endcase
  endtask

  // One clock: check outputs, score any issue, then advance the model across the edge.
  task automatic tick();
    ent_t        e, new_e;
    logic        exp_rdy, cap, do_flush, do_push, consume;
    logic [31:0] cap_val;
    logic [4:0]  cap_dst;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("pending", 64'(pending), 64'((mq.size() != 0) || (md_op != 4'd0) || md_busy));
    chk("res_valid", 64'(res_valid), 64'(ref_valid));
    chk("res_data", 64'(res_data), 64'(ref_data));
    chk("res_dst", 64'(res_dst), 64'(ref_dst));
    cap = 1'b0; cap_val = 32'd0; cap_dst = 5'd0;
    if (md_op != 4'd0) begin
      chk("issue_unit_idle", 64'(u_cnt), 64'd0);
      chk("issue_spacing", 64'((cyc - last_iss) >= 2), 64'd1);
      iss_cyc.push_back(cyc);
      last_iss = cyc;
      chk("issue_expected", 64'(mq.size() != 0), 64'd1);
      if (mq.size() != 0) begin
        e = mq.pop_front();
        chk("issue_op", 64'(md_op), 64'(e.op));
        chk("issue_rs", 64'(md_rs), 64'(e.rs));
        chk("issue_rt", 64'(md_rt), 64'(e.rt));
        if ((e.op == OP_MFHI) || (e.op == OP_MFLO)) begin
          chk("mf_while_result_held", 64'(prev_blk), 64'd0);
          cap = 1'b1;
          cap_val = (e.op == OP_MFHI) ? ref_hi : ref_lo;
          cap_dst = e.dst;
        end else begin
          ref_apply(e.op, e.rs, e.rt);
        end
      end
    end else begin
      chk("idle_operands", {md_rs, md_rt}, 64'd0);
    end
    last_acc = in_valid && exp_rdy;
    do_push  = in_valid && exp_rdy && (in_op != 4'd0) && !flush;
    do_flush = flush;
    new_e    = '{op: in_op, rs: in_rs, rt: in_rt, dst: in_dst};
    prev_blk = ref_valid && !res_ready;
    consume  = ref_valid && res_ready;
    @(posedge clk);
    cyc++;
    if (do_flush) mq.delete();
    else if (do_push) mq.push_back(new_e);
    if (cap) begin
      ref_valid = 1'b1; ref_data = cap_val; ref_dst = cap_dst;
    end else if (consume) begin
      ref_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] dst, output int waited);
    waited = 0;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_dst = dst;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (last_acc) break;
      waited++;
    end
    chk("push_accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0; in_op = 4'd0; in_rs = 32'd0; in_rt = 32'd0; in_dst = 5'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pending || (mq.size() != 0)) && (n < 80)) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(pending), 64'd0);
  endtask

  int t0, w, rv;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_op = 4'd0; in_rs = 32'd0; in_rt = 32'd0; in_dst = 5'd0;
    reset_model();

    // Reset values.
    @(negedge clk);
    chk("rst_md_op", 64'(md_op), 64'd0);
    chk("rst_md_rs_rt", {md_rs, md_rt}, 64'd0);
    chk("rst_res", {27'd0, res_dst, res_data}, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;

    // mult 7 * -3, then mflo to r8 behind the 5-cycle multiply.
    iss_cyc.delete();
    t0 = cyc;
    push_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 5'd0, w);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd8, w);
    run(12);
    chk("mult_issue_count", 64'(iss_cyc.size()), 64'd2);
    if (iss_cyc.size() >= 2) begin
      chk("mult_issue_latency", 64'(iss_cyc[0] - t0), 64'd2);
      chk("mflo_after_mult_gap", 64'(iss_cyc[1] - iss_cyc[0]), 64'd7);
    end
    chk("mflo_data", 64'(res_data), 64'hFFFF_FFEB);
    chk("mflo_dst", 64'(res_dst), 64'd8);
    chk("mflo_valid", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    tick();
    drain();

    // div 100/7 then mfhi with the consumer always ready.
    iss_cyc.delete();
    push_op(OP_DIV, 32'd100, 32'd7, 5'd0, w);
    push_op(OP_MFHI, 32'd0, 32'd0, 5'd3, w);
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rv += int'(res_valid);
    end
    chk("div_issue_count", 64'(iss_cyc.size()), 64'd2);
    if (iss_cyc.size() >= 2) chk("mfhi_after_div_gap", 64'(iss_cyc[1] - iss_cyc[0]), 64'd12);
    chk("mfhi_data", 64'(res_data), 64'd2);
    chk("mfhi_single_cycle_valid", 64'(rv), 64'd1);
    drain();

    // Fill the two-entry queue while a divide runs; third waits for the first issue.
    push_op(OP_DIVU, 32'd50, 32'd5, 5'd0, w);
    run(3);
    push_op(OP_MTLO, 32'h11, 32'd0, 5'd0, w);
    push_op(OP_MTHI, 32'h22, 32'd0, 5'd0, w);
    chk("full_in_ready_low", 64'(in_ready), 64'd0);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd9, w);
    chk("third_push_waited", 64'(w >= 5), 64'd1);
    drain();
    run(2);
    chk("order_mflo_data", 64'(res_data), 64'h11);
    chk("order_mflo_dst", 64'(res_dst), 64'd9);

    // Two mflo with the consumer stalled: second waits for the first to drain.
    res_ready = 1'b0;
    push_op(OP_MTLO, 32'hAAAA, 32'd0, 5'd0, w);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd1, w);
    push_op(OP_MTLO, 32'hBBBB, 32'd0, 5'd0, w);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd2, w);
    run(10);
    chk("held_first_data", 64'(res_data), 64'hAAAA);
    chk("held_first_dst", 64'(res_dst), 64'd1);
    chk("held_second_pending", 64'(pending), 64'd1);
    chk("held_md_op_quiet", 64'(md_op), 64'd0);
    res_ready = 1'b1;
    run(6);
    chk("second_data", 64'(res_data), 64'hBBBB);
    chk("second_dst", 64'(res_dst), 64'd2);
    drain();

    // flush during an active ISSUE with a second entry queued.
    push_op(OP_MULT, 32'd3, 32'd4, 5'd0, w);
    push_op(OP_MTLO, 32'h55, 32'd0, 5'd0, w);
    chk("flush_issue_active", 64'(md_op), 64'(OP_MULT));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    w = 0;
    while (pending && (w < 20)) begin
      tick();
      w++;
    end
    chk("flush_pending_falls", 64'(pending), 64'd0);
    chk("flush_pending_len", 64'(w), 64'd5);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd4, w);
    drain();
    run(2);
    chk("flush_dropped_mtlo", 64'(res_data), 64'd12);

    // Reset mid-divide with a result held.
    res_ready = 1'b0;
    push_op(OP_MTLO, 32'h77, 32'd0, 5'd0, w);
    push_op(OP_MFLO, 32'd0, 32'd0, 5'd5, w);
    run(3);
    push_op(OP_DIV, 32'd1000, 32'd3, 5'd0, w);
    push_op(OP_MTHI, 32'h99, 32'd0, 5'd0, w);
    run(4);
    chk("pre_reset_valid", 64'(res_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_md_op", 64'(md_op), 64'd0);
    chk("async_md_rs_rt", {md_rs, md_rt}, 64'd0);
    chk("async_res", {27'd0, res_dst, res_data}, 64'd0);
    chk("async_res_valid", 64'(res_valid), 64'd0);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_pending", 64'(pending), 64'd0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    run(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  op;
      logic [31:0] rs, rt;
      op = 4'($urandom_range(0, 8));
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (rt == 32'd0) rt = 32'd1;
      if ((op == OP_DIV) && (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF)) rt = 32'd3;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = op; in_rs = rs; in_rt = rt;
      in_dst    = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; in_op = 4'd0; res_ready = 1'b1;
    drain();
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
